// File: rtl/mips_prog_loader.sv
// Boot loader: framed byte stream -> big-endian words -> core memory, then XOR-checksum gate on core_start.
// Latency: a word's 4th byte accepted at cycle t raises mem_we at t+1; the csum byte sets core_start/load_err next cycle.
// Backpressure: in_ready drops only while a pending write sees mem_busy; mem_we/addr/data hold until accepted.
module mips_prog_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_busy,
    output logic              core_start,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, BASE_HI, BASE_LO, DATA, CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0]       DEPTH    = 17'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   WL_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          base_hi_q, base_hi_d;
    logic [ADDR_W-1:0]   addr_next_q, addr_next_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         word_q, word_d;
    logic [7:0]          csum_q, csum_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                core_start_q, core_start_d;
    logic                load_err_q, load_err_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;

    logic        accept;
    logic        wr_ack;
    logic [15:0] base_in;
    logic [16:0] end_addr;
    logic        hdr_bad;

    assign in_ready = !(mem_we_q && mem_busy);
    assign accept   = in_valid && in_ready;
    assign wr_ack   = mem_we_q && !mem_busy;

    // Header check in 17 bits so base+count can reach exactly DEPTH without wrapping.
    assign base_in  = {base_hi_q, in_data};
    assign end_addr = {1'b0, base_in} + {1'b0, cnt_q};
    assign hdr_bad  = (cnt_q == 16'd0) || ({1'b0, cnt_q} > DEPTH) ||
                      ((base_in >> ADDR_W) != 16'd0) || (end_addr > DEPTH);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        base_hi_d      = base_hi_q;
        addr_next_d    = addr_next_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_q;
        csum_d         = csum_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        core_start_d   = core_start_q;
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;

        if (wr_ack) begin
            mem_we_d       = 1'b0;
            words_loaded_d = words_loaded_q + WL_ONE;
        end

        if (accept) begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d        = CNT_HI;
                        csum_d         = 8'h00;
                        words_loaded_d = '0;
                        core_start_d   = 1'b0;
                        load_err_d     = 1'b0;
                    end
                end
                CNT_HI: begin
                    cnt_d[15:8] = in_data;
                    state_d     = CNT_LO;
                end
                CNT_LO: begin
                    cnt_d[7:0] = in_data;
                    state_d    = BASE_HI;
                end
                BASE_HI: begin
                    base_hi_d = in_data;
                    state_d   = BASE_LO;
                end
                BASE_LO: begin
                    if (hdr_bad) begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d     = DATA;
                        byte_idx_d  = 2'd0;
                        addr_next_d = base_in[ADDR_W-1:0];
                    end
                end
                DATA: begin
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0:    word_d[23:16] = in_data;
                        2'd1:    word_d[15:8]  = in_data;
                        2'd2:    word_d[7:0]   = in_data;
                        default: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_next_q;
                            mem_wdata_d = {word_q, in_data};
                            addr_next_d = addr_next_q + ADDR_ONE;
                            cnt_d       = cnt_q - 16'd1;
                            // The csum byte cannot be accepted until this final write clears mem_busy.
                            if (cnt_q == 16'd1) state_d = CSUM;
                        end
                    endcase
                end
                CSUM: begin
                    if (in_data == csum_q) begin
                        state_d      = DONE;
                        core_start_d = 1'b1;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            base_hi_q      <= '0;
            addr_next_q    <= '0;
            byte_idx_q     <= '0;
            word_q         <= '0;
            csum_q         <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            core_start_q   <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            base_hi_q      <= base_hi_d;
            addr_next_q    <= addr_next_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            core_start_q   <= core_start_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_start   = core_start_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: frame table plus stall/reset/garbage sequences, writes checked via a scoreboard queue.
module tb_mips_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_busy;
    logic              core_start;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    mips_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_busy     (mem_busy),
        .core_start   (core_start),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [15:0]  n;
        logic [15:0]  b;
        logic [2:0]   nw;
        logic [127:0] w;
        logic         bad;
        logic         exp_done;
        logic         exp_err;
        logic [10:0]  exp_wl;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Write scoreboard: every accepted write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1 && mem_busy === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                chk("wr_data", mem_wdata, mon_e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL byte_timeout: byte 0x%0h not accepted, expected acceptance within 100 cycles", b);
        end
    endtask

    task automatic send_body(input vec_t v, input string tag);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        send_byte(8'hA5);
        @(negedge clk);
        chk({tag, ".sync_core_start"}, 32'(core_start), 32'd0);
        chk({tag, ".sync_load_err"}, 32'(load_err), 32'd0);
        chk({tag, ".sync_words"}, 32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        send_byte(v.n[15:8]);
        send_byte(v.n[7:0]);
        send_byte(v.b[15:8]);
        send_byte(v.b[7:0]);
        for (int i = 0; i < int'(v.nw); i++) begin
            w = v.w[32*i +: 32];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[31:24]);
                cs = cs ^ w[31:24];
                w  = w << 8;
            end
        end
        if (v.nw != 3'd0) send_byte(cs ^ {7'd0, v.bad});
    endtask

    task automatic stall_seq(input vec_t v);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = (mem_we === 1'b1);
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL stall_wait: mem_we never rose, expected first write within 300 cycles");
        end else begin
            mem_busy = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("stall_mem_we", 32'(mem_we), 32'd1);
                chk("stall_addr", 32'(mem_addr), 32'(v.b[9:0]));
                chk("stall_data", mem_wdata, v.w[31:0]);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
            end
            mem_busy = 1'b0;
        end
    endtask

    task automatic run_frame(input vec_t v, input bit stall, input string tag);
        for (int i = 0; i < int'(v.nw); i++)
            exp_q.push_back('{addr: v.b[9:0] + 10'(i), data: v.w[32*i +: 32]});
        if (stall) begin
            fork
                send_body(v, tag);
                stall_seq(v);
            join
        end else begin
            send_body(v, tag);
        end
        @(negedge clk);
        chk({tag, ".core_start"}, 32'(core_start), 32'(v.exp_done));
        chk({tag, ".load_err"}, 32'(load_err), 32'(v.exp_err));
        chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(v.exp_wl));
        chk({tag, ".writes_pending"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, ".core_start"}, 32'(core_start), 32'd0);
        chk({tag, ".load_err"}, 32'(load_err), 32'd0);
        chk({tag, ".words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          n         b         nw    words (word0 in low 32 bits)                                bad  done err wl
        vecs[0] = '{16'd2,    16'h0000, 3'd2, {64'h0, 32'h9ABCDEF0, 32'h12345678},                      1'b0, 1'b1, 1'b0, 11'd2};
        vecs[1] = '{16'd2,    16'h0000, 3'd2, {64'h0, 32'h9ABCDEF0, 32'h12345678},                      1'b1, 1'b0, 1'b1, 11'd2};
        vecs[2] = '{16'd0,    16'h0000, 3'd0, 128'h0,                                                   1'b0, 1'b0, 1'b1, 11'd0};
        vecs[3] = '{16'd2,    16'h03FF, 3'd0, 128'h0,                                                   1'b0, 1'b0, 1'b1, 11'd0};
        vecs[4] = '{16'd1,    16'h03FF, 3'd1, {96'h0, 32'hDEADBEEF},                                    1'b0, 1'b1, 1'b0, 11'd1};
        vecs[5] = '{16'd2,    16'h00A5, 3'd2, {64'h0, 32'h0011A522, 32'hA5A5A5A5},                      1'b0, 1'b1, 1'b0, 11'd2};
        vecs[6] = '{16'h0401, 16'h0000, 3'd0, 128'h0,                                                   1'b0, 1'b0, 1'b1, 11'd0};
        vecs[7] = '{16'd1,    16'h0400, 3'd0, 128'h0,                                                   1'b0, 1'b0, 1'b1, 11'd0};
        vecs[8] = '{16'd4,    16'h03FC, 3'd4, {32'h0000A500, 32'hFFFFFFFF, 32'h01020304, 32'hCAFEF00D}, 1'b0, 1'b1, 1'b0, 11'd4};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        mem_busy = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        @(negedge clk);
        chk("garbage.core_start", 32'(core_start), 32'd0);
        chk("garbage.load_err", 32'(load_err), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run_frame(vecs[i], 1'b0, $sformatf("v%0d", i));

        send_byte(8'h00);
        send_byte(8'hFF);
        @(negedge clk);
        chk("done_garbage.core_start", 32'(core_start), 32'd1);
        @(posedge clk);
        #1;

        run_frame(vecs[0], 1'b1, "stall");

        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_reset.mem_we", 32'(mem_we), 32'd0);
        chk("post_reset.words_loaded", 32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;

        run_frame(vecs[4], 1'b0, "post_reset");
        run_frame(vecs[0], 1'b0, "final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
